// File: rtl/pulse_pkg.sv
// pulse_pkg: shared state encoding and default widths for the pulse-train generator.
package pulse_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;
   localparam int CHANNELS_DEF = 2;
   localparam int CNT_W_DEF = 8;
   localparam int NUM_W_DEF = 4;
endpackage

// File: rtl/pulse_channel.sv
// pulse_channel: one burst FSM with shadowed high/low lengths, phase counter and pulse counter.
module pulse_channel
   import pulse_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int NUM_W = NUM_W_DEF
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] high_len,
   input  logic [CNT_W-1:0] low_len,
   input  logic [NUM_W-1:0] pulses,
   output logic             signal,
   output logic             busy,
   output logic             done
);
   state_t           state;
   logic [CNT_W-1:0] h_sh, l_sh, cnt;
   logic [NUM_W-1:0] pcnt;
   logic [CNT_W-1:0] h_min, l_min;
   logic             last;
   // a zero length still yields a one-cycle phase
   assign h_min = (high_len == '0) ? CNT_W'(1) : high_len;
   assign l_min = (low_len == '0) ? CNT_W'(1) : low_len;
   assign last  = (cnt == CNT_W'(1));
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state  <= IDLE;
         h_sh   <= '0;
         l_sh   <= '0;
         cnt    <= '0;
         pcnt   <= '0;
         signal <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start && !abort) begin
               if (pulses != '0) begin
                  state  <= HIGH;
                  h_sh   <= h_min;
                  l_sh   <= l_min;
                  cnt    <= h_min;
                  pcnt   <= pulses;
                  signal <= 1'b1;
                  busy   <= 1'b1;
               end else
                  done <= 1'b1;
            end
         end else if (abort || (state == HIGH && last && pcnt == NUM_W'(1))) begin
            state  <= IDLE;
            signal <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
         end else if (!last)
            cnt <= cnt - CNT_W'(1);
         else if (state == HIGH) begin
            state  <= LOW;
            cnt    <= l_sh;
            signal <= 1'b0;
         end else begin
            state  <= HIGH;
            cnt    <= h_sh;
            pcnt   <= pcnt - NUM_W'(1);
            signal <= 1'b1;
         end
      end
endmodule

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: CHANNELS independent pulse_channel instances on packed configuration buses.
module pulse_train_gen
   import pulse_pkg::*;
#(
   parameter int CHANNELS = CHANNELS_DEF,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int NUM_W    = NUM_W_DEF
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [CHANNELS-1:0]       start,
   input  logic [CHANNELS-1:0]       abort,
   input  logic [CHANNELS*CNT_W-1:0] high_len,
   input  logic [CHANNELS*CNT_W-1:0] low_len,
   input  logic [CHANNELS*NUM_W-1:0] pulses,
   output logic [CHANNELS-1:0]       signal,
   output logic [CHANNELS-1:0]       busy,
   output logic [CHANNELS-1:0]       done
);
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      pulse_channel #(.CNT_W(CNT_W), .NUM_W(NUM_W)) u_ch (
         .clock   (clock),
         .reset_n (reset_n),
         .start   (start[i]),
         .abort   (abort[i]),
         .high_len(high_len[i*CNT_W +: CNT_W]),
         .low_len (low_len[i*CNT_W +: CNT_W]),
         .pulses  (pulses[i*NUM_W +: NUM_W]),
         .signal  (signal[i]),
         .busy    (busy[i]),
         .done    (done[i])
      );
   end
endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: directed checks of burst timing, independence, zero fields, abort and shadowing.
module tb_pulse_train_gen;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  start = '0, abort = '0;
   logic [15:0] high_len = '0, low_len = '0;
   logic [7:0]  pulses = '0;
   logic [1:0]  signal, busy, done;
   int          total = 0, passed = 0;
   int          bc [2];
   int          dt [2];
   logic [8:0]  pat;

   pulse_train_gen dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .abort   (abort),
      .high_len(high_len),
      .low_len (low_len),
      .pulses  (pulses),
      .signal  (signal),
      .busy    (busy),
      .done    (done)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic cfg(input int ch, input logic [7:0] h, input logic [7:0] l, input logic [3:0] p);
      high_len[ch*8 +: 8] = h;
      low_len[ch*8 +: 8]  = l;
      pulses[ch*4 +: 4]   = p;
   endtask

   task automatic fire(input logic [1:0] m);
      start = m;
      tick();
      start = '0;
   endtask

   initial begin
      #3;
      check("rst signal", 32'(signal), 0);
      check("rst busy", 32'(busy), 0);
      check("rst done", 32'(done), 0);
      @(negedge clock) reset_n = 1'b1;
      tick();
      // basic burst H=3 L=3 P=2
      cfg(0, 3, 3, 2);
      fire(2'b01);
      pat = 9'b111000111;
      for (int i = 0; i < 9; i++) begin
         check($sformatf("t2 sig%0d", i), 32'(signal[0]), 32'(pat[8-i]));
         check($sformatf("t2 busy%0d", i), 32'(busy[0]), 1);
         tick();
      end
      check("t2 end sig", 32'(signal[0]), 0);
      check("t2 end busy", 32'(busy[0]), 0);
      check("t2 done", 32'(done[0]), 1);
      tick();
      check("t2 done clr", 32'(done[0]), 0);
      // dual channel independence
      cfg(0, 3, 3, 3);
      cfg(1, 6, 6, 3);
      fire(2'b11);
      bc = '{0, 0};
      dt = '{-1, -1};
      for (int c = 0; c < 40; c++) begin
         for (int k = 0; k < 2; k++) begin
            if (busy[k]) bc[k]++;
            if (done[k] && dt[k] < 0) dt[k] = c;
         end
         tick();
      end
      check("t3 busy0", 32'(bc[0]), 15);
      check("t3 busy1", 32'(bc[1]), 30);
      check("t3 done0", 32'(dt[0]), 15);
      check("t3 done1", 32'(dt[1]), 30);
      check("t3 gap", 32'(dt[1] - dt[0]), 15);
      // zero pulse count
      cfg(0, 3, 3, 0);
      fire(2'b01);
      check("t4 p0 sig", 32'(signal[0]), 0);
      check("t4 p0 busy", 32'(busy[0]), 0);
      check("t4 p0 done", 32'(done[0]), 1);
      tick();
      check("t4 p0 done clr", 32'(done[0]), 0);
      // zero lengths
      cfg(0, 0, 0, 3);
      fire(2'b01);
      pat = 9'b000010101;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t4 z sig%0d", i), 32'(signal[0]), 32'(pat[4-i]));
         tick();
      end
      check("t4 z done", 32'(done[0]), 1);
      check("t4 z busy", 32'(busy[0]), 0);
      tick();
      // abort and ignored start
      cfg(0, 4, 4, 4);
      fire(2'b01);
      tick();
      fire(2'b01);
      tick();
      tick();
      check("t5 ign start", 32'(signal[0]), 0);
      check("t5 busy", 32'(busy[0]), 1);
      tick();
      abort = 2'b01;
      tick();
      abort = '0;
      check("t5 ab sig", 32'(signal[0]), 0);
      check("t5 ab busy", 32'(busy[0]), 0);
      check("t5 ab done", 32'(done[0]), 1);
      tick();
      check("t5 ab done clr", 32'(done[0]), 0);
      abort = 2'b01;
      fire(2'b01);
      abort = '0;
      check("t5 as busy", 32'(busy[0]), 0);
      check("t5 as done", 32'(done[0]), 0);
      tick();
      check("t5 as busy2", 32'(busy[0]), 0);
      // config change while busy
      cfg(0, 2, 1, 2);
      fire(2'b01);
      cfg(0, 5, 1, 2);
      pat = 9'b000011011;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t6 sig%0d", i), 32'(signal[0]), 32'(pat[4-i]));
         tick();
      end
      check("t6 done", 32'(done[0]), 1);
      tick();
      cfg(0, 5, 1, 1);
      fire(2'b01);
      bc[0] = 0;
      for (int i = 0; i < 5; i++) begin
         if (signal[0]) bc[0]++;
         tick();
      end
      check("t6 new high", 32'(bc[0]), 5);
      check("t6 new done", 32'(done[0]), 1);
      tick();
      // async reset mid-burst
      cfg(0, 4, 4, 4);
      fire(2'b01);
      tick();
      tick();
      #2 reset_n = 1'b0;
      #1;
      check("t1 rst sig", 32'(signal), 0);
      check("t1 rst busy", 32'(busy), 0);
      check("t1 rst done", 32'(done), 0);
      @(negedge clock) reset_n = 1'b1;
      tick();
      cfg(0, 1, 1, 1);
      fire(2'b01);
      check("t1 post sig", 32'(signal[0]), 1);
      check("t1 post busy", 32'(busy[0]), 1);
      tick();
      check("t1 post done", 32'(done[0]), 1);
      check("t1 post sig0", 32'(signal[0]), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
